uart_prog_loader: RTL

//  Framed, checksummed program loader between the UART byte receiver and the 6502 program RAM.

---
 rtl/uart_prog_pkg.sv | 21 ++
 rtl/prog_clear_engine.sv | 39 +++
 rtl/uart_prog_loader.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/uart_prog_pkg.sv
// Shared encodings for the UART program loader: FSM states, default SYNC marker
// and the byte positions inside the frame header.
package uart_prog_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_CHK,
    ST_WAIT_CLR,
    ST_BOOT
  } ldr_state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  localparam logic [1:0] HDR_ADDR_LO = 2'd0;
  localparam logic [1:0] HDR_ADDR_HI = 2'd1;
  localparam logic [1:0] HDR_LEN_LO  = 2'd2;
  localparam logic [1:0] HDR_LEN_HI  = 2'd3;

endpackage

// File: rtl/prog_clear_engine.sv
// Walks a fixed RAM region one word per cycle; the owner muxes the RAM port and
// may stall it for a cycle when a payload write needs the port.
module prog_clear_engine #(
  parameter int                ADDR_W = 16,
  parameter logic [ADDR_W-1:0] BASE   = '0,
  parameter logic [15:0]       LEN    = 16'h0600
) (
  input  logic              clk_ram,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              en,
  input  logic              stall,
  output logic [ADDR_W-1:0] addr,
  output logic              req,
  output logic              done
);

  logic [15:0] cnt;

  assign req  = en && !abort && (cnt != 16'h0000);
  assign done = (cnt == 16'h0000);

  always_ff @(posedge clk_ram) begin
    if (reset) begin
      addr <= '0;
      cnt  <= 16'h0000;
    end else if (start) begin
      addr <= BASE;
      cnt  <= LEN;
    end else if (abort) begin
      cnt  <= 16'h0000;
    end else if (req && !stall) begin
      addr <= addr + ADDR_W'(1);
      cnt  <= cnt - 16'd1;
    end
  end

endmodule

// File: rtl/uart_prog_loader.sv
// Framed, checksummed program loader: UART bytes in, RAM writes out, with a
// region clear during reception and a CPU reboot pulse on a good frame.
module uart_prog_loader
  import uart_prog_pkg::*;
#(
  parameter int          ADDR_W       = 16,
  parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEF,
  parameter logic [15:0] CLEAR_BASE   = 16'h0000,
  parameter logic [15:0] CLEAR_LEN    = 16'h0600,
  parameter logic [19:0] TIMEOUT      = 20'd250000,
  parameter int          RESET_CYCLES = 8
) (
  input  logic              clk_ram,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_strobe,
  output logic [ADDR_W-1:0] waddr,
  output logic [7:0]        wdata,
  output logic              write_en,
  output logic              ask_for_ram,
  output logic              end_of_data,
  output logic              busy,
  output logic              error
);

  localparam logic [7:0] BOOT_LAST = 8'(RESET_CYCLES - 1);

  ldr_state_t        state;
  logic [1:0]        hdr_idx;
  logic [7:0]        addr_lo;
  logic [ADDR_W-1:0] load_addr;
  logic [15:0]       load_len;
  logic [7:0]        sum;
  logic [19:0]       tmo_cnt;
  logic [7:0]        boot_cnt;

  logic              in_frame, sync_hit, data_wr, tmo_hit, chk_bad;
  logic [7:0]        sum_nxt;
  logic [15:0]       len_nxt;
  logic [ADDR_W-1:0] clr_addr;
  logic              clr_req, clr_done, clr_en, clr_abort;

  assign in_frame  = (state == ST_HDR) || (state == ST_DATA) || (state == ST_CHK);
  assign sum_nxt   = sum + rx_data;
  assign len_nxt   = {rx_data, load_len[7:0]};
  assign sync_hit  = (state == ST_IDLE) && rx_strobe && (rx_data == SYNC_BYTE);
  assign data_wr   = (state == ST_DATA) && rx_strobe;
  // A byte arriving on the expiry cycle wins; the timeout only fires on an idle cycle.
  assign tmo_hit   = in_frame && !rx_strobe && (tmo_cnt == TIMEOUT);
  assign chk_bad   = (state == ST_CHK) && rx_strobe && (sum_nxt != 8'h00);
  assign clr_en    = (state != ST_IDLE) && (state != ST_BOOT);
  assign clr_abort = tmo_hit || chk_bad;
  assign busy      = (state != ST_IDLE);

  prog_clear_engine #(
    .ADDR_W (ADDR_W),
    .BASE   (ADDR_W'(CLEAR_BASE)),
    .LEN    (CLEAR_LEN)
  ) u_clr (
    .clk_ram (clk_ram),
    .reset   (reset),
    .start   (sync_hit),
    .abort   (clr_abort),
    .en      (clr_en),
    .stall   (data_wr),
    .addr    (clr_addr),
    .req     (clr_req),
    .done    (clr_done)
  );

  always_ff @(posedge clk_ram) begin
    if (reset) begin
      state       <= ST_IDLE;
      waddr       <= '0;
      wdata       <= 8'h00;
      write_en    <= 1'b0;
      ask_for_ram <= 1'b0;
      end_of_data <= 1'b0;
      error       <= 1'b0;
      hdr_idx     <= 2'd0;
      addr_lo     <= 8'h00;
      load_addr   <= '0;
      load_len    <= 16'h0000;
      sum         <= 8'h00;
      tmo_cnt     <= 20'd0;
      boot_cnt    <= 8'd0;
    end else begin
      error    <= 1'b0;
      write_en <= 1'b0;
      // Payload has the RAM port; the clear engine is stalled on the same cycle.
      if (data_wr) begin
        write_en <= 1'b1;
        waddr    <= load_addr;
        wdata    <= rx_data;
      end else if (clr_req) begin
        write_en <= 1'b1;
        waddr    <= clr_addr;
        wdata    <= 8'h00;
      end

      if (in_frame) tmo_cnt <= rx_strobe ? 20'd0 : tmo_cnt + 20'd1;

      case (state)
        ST_IDLE: if (sync_hit) begin
          state       <= ST_HDR;
          ask_for_ram <= 1'b1;
          sum         <= 8'h00;
          hdr_idx     <= HDR_ADDR_LO;
          tmo_cnt     <= 20'd0;
        end
        ST_HDR: if (rx_strobe) begin
          sum     <= sum_nxt;
          hdr_idx <= hdr_idx + 2'd1;
          case (hdr_idx)
            HDR_ADDR_LO: addr_lo   <= rx_data;
            HDR_ADDR_HI: load_addr <= ADDR_W'({rx_data, addr_lo});
            HDR_LEN_LO:  load_len  <= {8'h00, rx_data};
            HDR_LEN_HI: begin
              load_len <= len_nxt;
              state    <= (len_nxt == 16'h0000) ? ST_CHK : ST_DATA;
            end
            default: ;
          endcase
        end
        ST_DATA: if (rx_strobe) begin
          sum       <= sum_nxt;
          load_addr <= load_addr + ADDR_W'(1);
          load_len  <= load_len - 16'd1;
          if (load_len == 16'd1) state <= ST_CHK;
        end
        ST_CHK: if (rx_strobe) begin
          if (sum_nxt == 8'h00) begin
            state <= ST_WAIT_CLR;
          end else begin
            error       <= 1'b1;
            ask_for_ram <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        ST_WAIT_CLR: if (clr_done) begin
          state       <= ST_BOOT;
          ask_for_ram <= 1'b0;
          end_of_data <= 1'b1;
          boot_cnt    <= 8'd0;
        end
        ST_BOOT: begin
          if (boot_cnt == BOOT_LAST) begin
            end_of_data <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            boot_cnt <= boot_cnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (tmo_hit) begin
        error       <= 1'b1;
        ask_for_ram <= 1'b0;
        state       <= ST_IDLE;
      end
    end
  end

endmodule
